// File: rtl/sdram_line_prefetch.sv
// Single-line read-prefetch buffer in front of the SDRAM controller's burst-read port.
// A miss fetches one whole aligned line as a 32-bit-mode burst. Later hits to that
// line are served from the local buffer without another SDRAM access.
module sdram_line_prefetch #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic        controller_clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [25:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_ack,
  input  logic        invalidate,
  output logic        line_valid,
  output logic        burst_rd,
  output logic [25:0] burst_addr,
  output logic [10:0] burst_len,
  output logic        burst_32bit,
  input  logic [31:0] burst_data,
  input  logic        burst_data_valid,
  input  logic        burst_data_done
);

  localparam int unsigned LW = $clog2(LINE_WORDS);
  localparam int unsigned TW = 24 - LW;
  localparam logic [LW:0] FULL_CNT = LINE_WORDS[LW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FILL,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   line_tag_q, line_tag_d;
  logic [LW:0]     fill_cnt_q, fill_cnt_d;
  logic            discard_q, discard_d;
  logic            line_valid_q, line_valid_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            rd_ack_q, rd_ack_d;
  logic [31:0]     line_buf_q [LINE_WORDS];
  logic            buf_we;

  logic [TW-1:0]   req_tag;
  logic [LW-1:0]   req_idx;
  logic            hit;
  logic            unused_addr_bits;

  assign req_tag          = rd_addr[25:LW+2];
  assign req_idx          = rd_addr[LW+1:2];
  assign unused_addr_bits = ^rd_addr[1:0];
  // Invalidate in the same cycle beats a would-be hit.
  assign hit = rd_req && line_valid_q && (req_tag == line_tag_q) && !invalidate;

  assign rd_data     = rd_data_q;
  assign rd_ack      = rd_ack_q;
  assign line_valid  = line_valid_q;
  assign burst_rd    = (state_q == S_ISSUE);
  assign burst_addr  = {line_tag_q, {(LW+2){1'b0}}};
  assign burst_len   = 11'(2 * LINE_WORDS);
  assign burst_32bit = 1'b1;

  // Next-state and register updates for the lookup/fill sequencer.
  always_comb begin
    state_d      = state_q;
    line_tag_d   = line_tag_q;
    fill_cnt_d   = fill_cnt_q;
    discard_d    = discard_q;
    line_valid_d = line_valid_q;
    rd_data_d    = rd_data_q;
    rd_ack_d     = 1'b0;
    buf_we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (invalidate) line_valid_d = 1'b0;
        if (rd_req) begin
          if (hit) begin
            rd_data_d = line_buf_q[req_idx];
            state_d   = S_RESP;
          end else begin
            line_tag_d   = req_tag;
            fill_cnt_d   = '0;
            discard_d    = 1'b0;
            line_valid_d = 1'b0;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (invalidate) discard_d = 1'b1;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (invalidate) discard_d = 1'b1;
        if (burst_data_valid && (fill_cnt_q < FULL_CNT)) begin
          buf_we     = 1'b1;
          fill_cnt_d = fill_cnt_q + (LW+1)'(1);
        end
        // Completion sees a word and an invalidate arriving in the done cycle.
        if (burst_data_done) begin
          line_valid_d = (fill_cnt_d == FULL_CNT) && !discard_d;
          state_d      = S_IDLE;
        end
      end
      S_RESP: begin
        if (invalidate) line_valid_d = 1'b0;
        rd_ack_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers, asynchronously cleared.
  always_ff @(posedge controller_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      line_tag_q   <= '0;
      fill_cnt_q   <= '0;
      discard_q    <= 1'b0;
      line_valid_q <= 1'b0;
      rd_data_q    <= '0;
      rd_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_tag_q   <= line_tag_d;
      fill_cnt_q   <= fill_cnt_d;
      discard_q    <= discard_d;
      line_valid_q <= line_valid_d;
      rd_data_q    <= rd_data_d;
      rd_ack_q     <= rd_ack_d;
    end
  end

  // Line buffer write port; contents are only trusted while line_valid is set.
  always_ff @(posedge controller_clk) begin
    if (buf_we) line_buf_q[fill_cnt_q[LW-1:0]] <= burst_data;
  end

endmodule

// File: tb/tb_sdram_line_prefetch.sv
// Directed bench for sdram_line_prefetch with a simple burst-returning controller model
// and a read-data scoreboard.
module tb_sdram_line_prefetch;

  localparam int unsigned LINE_WORDS = 8;

  logic        controller_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [25:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        invalidate = 1'b0;
  logic        line_valid;
  logic        burst_rd;
  logic [25:0] burst_addr;
  logic [10:0] burst_len;
  logic        burst_32bit;
  logic [31:0] burst_data = '0;
  logic        burst_data_valid = 1'b0;
  logic        burst_data_done = 1'b0;

  sdram_line_prefetch #(.LINE_WORDS(LINE_WORDS)) dut (
    .controller_clk   (controller_clk),
    .reset_n          (reset_n),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .rd_ack           (rd_ack),
    .invalidate       (invalidate),
    .line_valid       (line_valid),
    .burst_rd         (burst_rd),
    .burst_addr       (burst_addr),
    .burst_len        (burst_len),
    .burst_32bit      (burst_32bit),
    .burst_data       (burst_data),
    .burst_data_valid (burst_data_valid),
    .burst_data_done  (burst_data_done)
  );

  always #5 controller_clk = ~controller_clk;

  int n_cmp = 0;
  int n_fail = 0;
  int ack_cnt = 0;
  int burst_cnt = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory contents the controller model returns for a given line.
  function automatic logic [31:0] word_of(input logic [25:0] line, input int i);
    if (line == 26'h120) return 32'hA0 + 32'(i);
    return ({6'b0, line} << 8) + 32'(i);
  endfunction

  // Scoreboard pop on every ack; burst pulse counting.
  always @(negedge controller_clk) begin
    if (reset_n && rd_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) check("unexpected_ack", {31'b0, rd_ack}, 32'd0);
      else check("rd_data", rd_data, exp_q.pop_front());
    end
    if (burst_rd) burst_cnt++;
  end

  task automatic req_start(input logic [25:0] a);
    @(negedge controller_clk);
    rd_req  = 1'b1;
    rd_addr = a;
    exp_q.push_back(word_of({a[25:5], 5'b0}, int'(a[4:2])));
  endtask

  task automatic wait_burst(output logic [25:0] a);
    bit got;
    got = 1'b0;
    a = '0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge controller_clk);
      if (burst_rd) begin
        got = 1'b1;
        a = burst_addr;
      end
    end
    check("burst_seen", {31'b0, got}, 32'd1);
    if (got) check("burst_len", {21'b0, burst_len}, 32'd16);
  endtask

  task automatic send_beats(input logic [25:0] a, input int n, input int inv_beat);
    for (int i = 0; i < n; i++) begin
      @(negedge controller_clk);
      burst_data_valid = 1'b1;
      burst_data       = word_of(a, i);
      invalidate       = (i == inv_beat);
    end
    @(negedge controller_clk);
    burst_data_valid = 1'b0;
    burst_data       = '0;
    invalidate       = 1'b0;
    burst_data_done  = 1'b1;
    @(negedge controller_clk);
    burst_data_done  = 1'b0;
  endtask

  task automatic serve(input int n, input int inv_beat, output logic [25:0] a);
    wait_burst(a);
    send_beats(a, n, inv_beat);
  endtask

  task automatic wait_ack(output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge controller_clk);
      cycles++;
      if (rd_ack) got = 1'b1;
    end
    rd_req = 1'b0;
    check("ack_seen", {31'b0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] a;
    int cyc, b0, a0;

    // Reset state
    repeat (3) @(negedge controller_clk);
    check("rst_rd_ack", {31'b0, rd_ack}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_burst_rd", {31'b0, burst_rd}, 32'd0);
    check("rst_burst_addr", {6'b0, burst_addr}, 32'd0);
    check("rst_line_valid", {31'b0, line_valid}, 32'd0);
    check("burst_32bit", {31'b0, burst_32bit}, 32'd1);
    reset_n = 1'b1;

    // Cold miss
    b0 = burst_cnt; a0 = ack_cnt;
    req_start(26'h124);
    serve(8, -1, a);
    check("cold_burst_addr", {6'b0, a}, 32'h120);
    wait_ack(cyc);
    repeat (3) @(negedge controller_clk);
    check("cold_burst_count", 32'(burst_cnt - b0), 32'd1);
    check("cold_ack_count", 32'(ack_cnt - a0), 32'd1);
    check("cold_line_valid", {31'b0, line_valid}, 32'd1);

    // Hit after fill
    b0 = burst_cnt;
    req_start(26'h13C);
    wait_ack(cyc);
    check("hit_latency", 32'(cyc), 32'd2);
    repeat (2) @(negedge controller_clk);
    check("hit_no_burst", 32'(burst_cnt - b0), 32'd0);

    // Short burst then retry
    req_start(26'h208);
    serve(5, -1, a);
    check("short_burst_addr", {6'b0, a}, 32'h200);
    check("short_line_valid", {31'b0, line_valid}, 32'd0);
    serve(8, -1, a);
    check("retry_burst_addr", {6'b0, a}, 32'h200);
    wait_ack(cyc);

    // Invalidate during the third beat
    req_start(26'h31C);
    serve(8, 2, a);
    check("inv_fill_addr", {6'b0, a}, 32'h300);
    check("inv_fill_line_valid", {31'b0, line_valid}, 32'd0);
    serve(8, -1, a);
    check("inv_retry_addr", {6'b0, a}, 32'h300);
    wait_ack(cyc);
    repeat (2) @(negedge controller_clk);
    check("inv_retry_line_valid", {31'b0, line_valid}, 32'd1);

    // Hit and invalidate together
    a0 = ack_cnt;
    req_start(26'h304);
    invalidate = 1'b1;
    @(negedge controller_clk);
    invalidate = 1'b0;
    check("hitinv_burst_rd", {31'b0, burst_rd}, 32'd1);
    check("hitinv_burst_addr", {6'b0, burst_addr}, 32'h300);
    send_beats(26'h300, 8, -1);
    check("hitinv_no_early_ack", 32'(ack_cnt - a0), 32'd0);
    wait_ack(cyc);

    // Reset during fill
    req_start(26'h404);
    wait_burst(a);
    for (int i = 0; i < 3; i++) begin
      @(negedge controller_clk);
      burst_data_valid = 1'b1;
      burst_data = word_of(a, i);
    end
    b0 = burst_cnt; a0 = ack_cnt;
    #2 reset_n = 1'b0;
    #1;
    check("arst_rd_ack", {31'b0, rd_ack}, 32'd0);
    check("arst_rd_data", rd_data, 32'd0);
    check("arst_burst_rd", {31'b0, burst_rd}, 32'd0);
    check("arst_burst_addr", {6'b0, burst_addr}, 32'd0);
    check("arst_line_valid", {31'b0, line_valid}, 32'd0);
    rd_req = 1'b0;
    exp_q.delete();
    for (int i = 3; i < 8; i++) begin
      @(negedge controller_clk);
      if (i == 5) reset_n = 1'b1;
      burst_data = word_of(a, i);
    end
    @(negedge controller_clk);
    burst_data_valid = 1'b0;
    burst_data_done = 1'b1;
    @(negedge controller_clk);
    burst_data_done = 1'b0;
    repeat (3) @(negedge controller_clk);
    check("post_rst_line_valid", {31'b0, line_valid}, 32'd0);
    check("post_rst_no_burst", 32'(burst_cnt - b0), 32'd0);
    check("post_rst_no_ack", 32'(ack_cnt - a0), 32'd0);

    // First request after reset misses
    req_start(26'h124);
    serve(8, -1, a);
    check("post_rst_miss_addr", {6'b0, a}, 32'h120);
    wait_ack(cyc);
    repeat (3) @(negedge controller_clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
